// File: rtl/regfile_pkg.sv
// Shared register-file types and system-default geometry used by the decoder, hazard unit and regfile.
package regfile_pkg;

  typedef enum logic {RF_INIT, RF_RUN} rf_state_t;

  localparam int unsigned RF_DW = 32;
  localparam int unsigned RF_AW = 5;
  localparam int unsigned RF_NR = 2;

endpackage

// File: rtl/regfile_if.sv
// Register-file access bus: two write ports, NR packed read ports and the init-done flag.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int unsigned DW = RF_DW,
  parameter int unsigned AW = RF_AW,
  parameter int unsigned NR = RF_NR
);

  logic             we0;
  logic [AW-1:0]    wa0;
  logic [DW-1:0]    wd0;
  logic             we1;
  logic [AW-1:0]    wa1;
  logic [DW-1:0]    wd1;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd;
  logic             ready;

  modport master (
    output we0, wa0, wd0, we1, wa1, wd1, ra,
    input  rd, ready
  );

  modport slave (
    input  we0, wa0, wd0, we1, wa1, wd1, ra,
    output rd, ready
  );

endinterface

// File: rtl/regfile_init_ctl.sv
// Post-reset clear sequencer: walks every entry once, then enters RUN and raises ready.
module regfile_init_ctl
  import regfile_pkg::*;
#(
  parameter int unsigned AW = RF_AW
) (
  input  logic          clk,
  input  logic          rst,
  output rf_state_t     o_state,
  output logic          o_clr_we_c,
  output logic [AW-1:0] o_clr_addr,
  output logic          o_ready
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;

  rf_state_t       r_state;
  rf_state_t       w_state_nxt;
  logic [CW-1:0]   r_clr_cnt;
  logic [CW-1:0]   w_clr_cnt_nxt;
  logic            r_ready;
  logic            w_ready_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RF_INIT;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  // One entry cleared per cycle; the last clear moves to RUN together with ready.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_ready_nxt   = r_ready;
    o_clr_we_c    = 1'b0;
    case (r_state)
      RF_INIT: begin
        o_clr_we_c    = !rst;
        w_clr_cnt_nxt = r_clr_cnt + CW'(1);
        if (r_clr_cnt == CW'(DEPTH - 1)) begin
          w_state_nxt = RF_RUN;
          w_ready_nxt = 1'b1;
        end
      end
      RF_RUN: begin
        w_state_nxt = RF_RUN;
      end
      default: begin
        w_state_nxt = RF_INIT;
      end
    endcase
  end

  assign o_state    = r_state;
  assign o_clr_addr = r_clr_cnt[AW-1:0];
  assign o_ready    = r_ready;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NR combinational reads, two synchronous writes, self-clearing init.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DW       = RF_DW,
  parameter int unsigned AW       = RF_AW,
  parameter int unsigned NR       = RF_NR,
  parameter int unsigned ZERO_REG = 1
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave rf_bus
);

  localparam int unsigned DEPTH = 1 << AW;

  rf_state_t     w_state;
  logic          w_clr_we;
  logic [AW-1:0] w_clr_addr;
  logic          w_ready;
  logic          w_run;
  logic          w_we0;
  logic          w_we1;

  logic [DW-1:0] r_rf [DEPTH];

  regfile_init_ctl #(
    .AW (AW)
  ) u_init_ctl (
    .clk        (clk),
    .rst        (rst),
    .o_state    (w_state),
    .o_clr_we_c (w_clr_we),
    .o_clr_addr (w_clr_addr),
    .o_ready    (w_ready)
  );

  // Functional writes only in RUN and never to a hardwired-zero entry.
  assign w_run = (w_state == RF_RUN) && !rst;
  assign w_we0 = w_run && rf_bus.we0 && !((ZERO_REG != 0) && (rf_bus.wa0 == '0));
  assign w_we1 = w_run && rf_bus.we1 && !((ZERO_REG != 0) && (rf_bus.wa1 == '0));

  // Init clear wins over both ports; port 1 is applied last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_rf[w_clr_addr] <= '0;
    end else begin
      if (w_we0) r_rf[rf_bus.wa0] <= rf_bus.wd0;
      if (w_we1) r_rf[rf_bus.wa1] <= rf_bus.wd1;
    end
  end

  for (genvar g = 0; g < NR; g++) begin : g_rd_port
    logic [AW-1:0] w_ra;
    logic [DW-1:0] w_rd;

    assign w_ra = rf_bus.ra[g*AW +: AW];

    always_comb begin
      w_rd = '0;
      if ((w_state == RF_RUN) && !((ZERO_REG != 0) && (w_ra == '0))) begin
        w_rd = r_rf[w_ra];
`ifdef REGFILE_BYPASS_EN
        if (w_we0 && (rf_bus.wa0 == w_ra)) w_rd = rf_bus.wd0;
        if (w_we1 && (rf_bus.wa1 == w_ra)) w_rd = rf_bus.wd1;
`endif
      end
    end

    assign rf_bus.rd[g*DW +: DW] = w_rd;
  end

  assign rf_bus.ready = w_ready;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: ZERO_REG=1 and ZERO_REG=0 instances on shared stimulus,
// directed table, multi-cycle reset/bypass sequences and random traffic against an array model.
module tb_regfile_mp;

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ez0;
    logic [31:0] ez1;
    logic [31:0] en0;
    logic [31:0] en1;
  } vec_t;

  logic clk;
  logic rst;

  regfile_if bus ();
  regfile_if bus_n ();

  assign bus_n.we0 = bus.we0;
  assign bus_n.wa0 = bus.wa0;
  assign bus_n.wd0 = bus.wd0;
  assign bus_n.we1 = bus.we1;
  assign bus_n.wa1 = bus.wa1;
  assign bus_n.wd1 = bus.wd1;
  assign bus_n.ra  = bus.ra;

  regfile_mp #(.DW(32), .AW(5), .NR(2), .ZERO_REG(1)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .rf_bus (bus)
  );

  regfile_mp #(.DW(32), .AW(5), .NR(2), .ZERO_REG(0)) u_dut_nz (
    .clk    (clk),
    .rst    (rst),
    .rf_bus (bus_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: two plain arrays plus an "initialising" flag and clear position.
  logic [31:0] mz [32];
  logic [31:0] mn [32];
  bit          m_init = 1'b1;
  int          m_pos  = 0;

  function automatic logic [31:0] exp_rd(bit zr, logic [4:0] a);
    if (m_init) return 32'h0;
    if (zr && a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (!rst) begin
      if (bus.we1 && bus.wa1 == a && !(zr && bus.wa1 == 5'd0)) return bus.wd1;
      if (bus.we0 && bus.wa0 == a && !(zr && bus.wa0 == 5'd0)) return bus.wd0;
    end
`endif
    return zr ? mz[a] : mn[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_init = 1'b1;
      m_pos  = 0;
    end else if (m_init) begin
      mz[m_pos] = 32'h0;
      mn[m_pos] = 32'h0;
      m_pos++;
      if (m_pos == 32) m_init = 1'b0;
    end else begin
      if (bus.we0) begin
        mn[bus.wa0] = bus.wd0;
        if (bus.wa0 != 5'd0) mz[bus.wa0] = bus.wd0;
      end
      if (bus.we1) begin
        mn[bus.wa1] = bus.wd1;
        if (bus.wa1 != 5'd0) mz[bus.wa1] = bus.wd1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, " ready_z"}, 32'(bus.ready), 32'(!m_init));
    chk({tag, " ready_n"}, 32'(bus_n.ready), 32'(!m_init));
    chk({tag, " rd0_z"}, bus.rd[31:0], exp_rd(1'b1, bus.ra[4:0]));
    chk({tag, " rd1_z"}, bus.rd[63:32], exp_rd(1'b1, bus.ra[9:5]));
    chk({tag, " rd0_n"}, bus_n.rd[31:0], exp_rd(1'b0, bus.ra[4:0]));
    chk({tag, " rd1_n"}, bus_n.rd[63:32], exp_rd(1'b0, bus.ra[9:5]));
  endtask

  function automatic vec_t mk(logic we0, logic [4:0] wa0, logic [31:0] wd0,
                              logic we1, logic [4:0] wa1, logic [31:0] wd1,
                              logic [4:0] ra0, logic [4:0] ra1,
                              logic [31:0] ez0, logic [31:0] ez1,
                              logic [31:0] en0, logic [31:0] en1);
    vec_t v;
    v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
    v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
    v.ra0 = ra0; v.ra1 = ra1;
    v.ez0 = ez0; v.ez1 = ez1; v.en0 = en0; v.en1 = en1;
    return v;
  endfunction

  function automatic logic [4:0] rnd_addr();
    return ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [5];
    int   n;
    logic [31:0] exp_byp;

    tbl[0] = mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0, 32'h0,
                5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0);
    tbl[1] = mk(1, 5'd7,  32'h00001111, 1, 5'd7, 32'h00002222,
                5'd7, 5'd5, 32'h00002222, 32'hDEADBEEF, 32'h00002222, 32'hDEADBEEF);
    tbl[2] = mk(1, 5'd0,  32'hFFFFFFFF, 0, 5'd0, 32'h0,
                5'd0, 5'd7, 32'h0, 32'h00002222, 32'hFFFFFFFF, 32'h00002222);
    tbl[3] = mk(1, 5'd3,  32'hA5A5A5A5, 1, 5'd9, 32'h00000001,
                5'd3, 5'd9, 32'hA5A5A5A5, 32'h00000001, 32'hA5A5A5A5, 32'h00000001);
    tbl[4] = mk(1, 5'd31, 32'hCAFEF00D, 1, 5'd0, 32'h12345678,
                5'd31, 5'd0, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'h12345678);

    rst = 1'b1;
    bus.we0 = 1'b0; bus.wa0 = '0; bus.wd0 = '0;
    bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0;
    bus.ra  = '0;

    // Reset held two edges, then exactly 32 cycles of INIT with writes attempted and ignored.
    cycle();
    cycle();
    rst = 1'b0;
    for (int c = 0; c <= 32; c++) begin
      bus.we0 = 1'($urandom); bus.wa0 = 5'($urandom); bus.wd0 = $urandom;
      bus.we1 = 1'($urandom); bus.wa1 = 5'($urandom); bus.wd1 = $urandom;
      bus.ra  = 10'($urandom);
      #1;
      chk($sformatf("init_ready c=%0d", c), 32'(bus.ready), (c == 32) ? 32'h1 : 32'h0);
      check_all("init");
      if (c < 32) cycle();
    end
    bus.we0 = 1'b0; bus.we1 = 1'b0;

    // Directed writes: basic, collision, zero register, dual port, port-1 to entry 0.
    for (int i = 0; i < 5; i++) begin
      bus.we0 = tbl[i].we0; bus.wa0 = tbl[i].wa0; bus.wd0 = tbl[i].wd0;
      bus.we1 = tbl[i].we1; bus.wa1 = tbl[i].wa1; bus.wd1 = tbl[i].wd1;
      bus.ra  = {tbl[i].ra1, tbl[i].ra0};
      cycle();
      bus.we0 = 1'b0; bus.we1 = 1'b0;
      #1;
      chk($sformatf("tbl%0d rd0_z", i), bus.rd[31:0],    tbl[i].ez0);
      chk($sformatf("tbl%0d rd1_z", i), bus.rd[63:32],   tbl[i].ez1);
      chk($sformatf("tbl%0d rd0_n", i), bus_n.rd[31:0],  tbl[i].en0);
      chk($sformatf("tbl%0d rd1_n", i), bus_n.rd[63:32], tbl[i].en1);
      check_all("tbl");
    end

    // Same-cycle write and read of reg 9 (old 0x1, new 0x2).
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'h2;
`else
    exp_byp = 32'h1;
`endif
    bus.we0 = 1'b1; bus.wa0 = 5'd9; bus.wd0 = 32'h2;
    bus.ra  = {5'd9, 5'd9};
    #1;
    chk("same_cycle rd0_z", bus.rd[31:0], exp_byp);
    chk("same_cycle rd1_n", bus_n.rd[63:32], exp_byp);
    check_all("same_cycle");
    cycle();
    bus.we0 = 1'b0;
    #1;
    chk("next_cycle rd0_z", bus.rd[31:0], 32'h2);
    check_all("next_cycle");

    // Reset, interrupt INIT at cycle 10, then write reg 3 throughout the second INIT.
    bus.ra = {5'd9, 5'd3};
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (10) cycle();
    check_all("mid_init");
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.we0 = 1'b1; bus.wa0 = 5'd3; bus.wd0 = 32'h55555555;
    n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      cycle();
      n++;
      check_all("reinit");
    end
    chk("reinit_cycles", 32'(n), 32'd32);
    bus.we0 = 1'b0;
    #1;
    chk("reinit reg3_z", bus.rd[31:0], 32'h0);
    chk("reinit reg3_n", bus_n.rd[31:0], 32'h0);
    check_all("reinit_done");

    // Random traffic with address collisions, read-after-write and rare resets.
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.we0 = 1'($urandom); bus.wa0 = rnd_addr(); bus.wd0 = $urandom;
      bus.we1 = 1'($urandom);
      bus.wa1 = ($urandom_range(0, 3) == 0) ? bus.wa0 : rnd_addr();
      bus.wd1 = $urandom;
      for (int p = 0; p < 2; p++) begin
        logic [4:0] a;
        case ($urandom_range(0, 2))
          0:       a = bus.wa0;
          1:       a = bus.wa1;
          default: a = rnd_addr();
        endcase
        bus.ra[p*5 +: 5] = a;
      end
      #1;
      check_all("rand");
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
